cpu_dmem_responder: RTL and testbench
=====================================

Name: cpu_dmem_responder

Overview:
- Responder end of the commit-stage memory request/response interface.
- Consumes the TLB/cache request signals and produces tlb_hit, cache_hit and cache_data_out.
- Contains a fully associative data TLB and a direct-mapped, write-through, read-allocate data cache.
- Misses and all stores go to the memory system over a req/ack handshake. The commit stage stalls until cache_hit.

Parameters:
- VADDR_W, 32, virtual address width (VIRTUAL_ADDR_WIDTH)
- PADDR_W, 20, physical address width (PHYSICAL_ADDR_WIDTH)
- WORD_W, 32, data word width (REG_WIDTH = WORD_WIDTH)
- PAGE_BITS, 12, page offset bits
- TLB_ENTRIES, 4, TLB entries (power of 2)
- CACHE_LINES, 4, cache lines (power of 2)
- LINE_WORDS, 4, words per line (power of 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tlb_enable  in  1  translation on; 0 = identity mapping, low PADDR_W bits
- tlb_write  in  1  install a mapping this cycle
- tlb_addr  in  VADDR_W  virtual address to translate or install
- tlb_data  in  PADDR_W  physical address whose page number is installed
- tlb_hit  out  1  translation valid
- cache_read  in  1  load request
- cache_write  in  1  store request
- cache_mode  in  cache_mode_e  CACHE_MODE_WORD or CACHE_MODE_BYTE
- cache_addr  in  VADDR_W  access address; the same address as tlb_addr
- cache_data_in  in  WORD_W  store data
- cache_hit  out  1  access complete; load data valid
- cache_data_out  out  WORD_W  load data
- mem_req  out  1  memory request
- mem_we  out  1  1 = word write, 0 = line read
- mem_addr  out  PADDR_W  physical address; line-aligned for reads
- mem_wdata  out  WORD_W  write data, already lane-placed
- mem_be  out  4  byte enables for writes
- mem_ack  in  1  request completed this cycle
- mem_rdata  in  WORD_W*LINE_WORDS  refill line; word 0 in the LSBs

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset
  - All TLB and cache valid bits cleared; TLB replacement pointer = 0; FSM in IDLE.
  - Outputs: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, cache_hit = 0, cache_data_out = 0, tlb_hit = 0.
  - Reset mid-transaction abandons it; a mem_ack arriving after reset is ignored.
- TLB
  - tlb_hit is combinational: (!tlb_enable) | any valid entry with VPN = tlb_addr[VADDR_W-1:PAGE_BITS].
  - Physical address = {PPN, addr[PAGE_BITS-1:0]}.
  - Install (tlb_write = 1): if the VPN already matches an entry, overwrite that entry; otherwise write the entry at the replacement pointer and increment the pointer (wraps modulo TLB_ENTRIES).
  - A new entry is visible the next cycle.
  - tlb_write has priority over cache access in the same cycle; the cache ignores that cycle.
- Cache addressing
  - Line index and tag come from the physical address. Offset = log2(LINE_WORDS*4) bits.
- FSM states: IDLE, REFILL, STORE, RESP.
- IDLE
  - No request, or tlb_hit = 0: cache_hit = 0 and no memory activity. A TLB miss is reported only through tlb_hit = 0.
  - Load hit: cache_hit = 1 in the same cycle (combinational), cache_data_out = selected word or byte. Stay in IDLE.
  - Load miss: go to REFILL. mem_req = 1, mem_we = 0, mem_addr = line-aligned physical address.
  - Store (hit or miss): go to STORE. mem_req = 1, mem_we = 1, mem_addr = word-aligned physical address.
  - Word store: mem_be = 4'b1111.
  - Byte store: mem_be = 1 << addr[1:0]; mem_wdata = data byte replicated across all 4 lanes.
  - cache_read and cache_write both high: store wins.
- REFILL
  - Hold mem_* until mem_ack. On ack: write line, tag and valid; drop mem_req; go to RESP.
- STORE
  - Hold mem_* until mem_ack. On ack: if the line is valid with a matching tag, merge the enabled bytes into it (no allocate on miss). Drop mem_req; go to RESP.
- RESP
  - cache_hit = 1 for exactly one cycle (registered).
  - For a load, cache_data_out comes from the newly filled line.
  - Return to IDLE.
- Latency: load hit 0 cycles; load miss 1 + memory latency + 1; store 1 + memory latency + 1.
- Data format
  - Byte loads are zero-extended, byte selected by addr[1:0].
  - Word accesses ignore addr[1:0].
- Requester obligations: the requester holds request signals stable until cache_hit. A request dropped mid-transaction still completes the memory transaction.
- mem_req never deasserts before mem_ack. At most one outstanding memory request.

Test Plan:
- tlb_enable = 0, word load 0x00000040 after reset → tlb_hit = 1. REFILL to mem_addr 0x00040. mem_rdata words {0x44, 0x33, 0x22, 0x11} (word 0 = 0x11). cache_hit pulses 1 cycle with data 0x11. An immediate reload of 0x44 hits combinationally with data 0x22.
- Install VPN 0x12345 → PPN 0xAB; load 0x12345008 → mem_addr 0xAB000. A 5th install with 4 entries full overwrites entry 0; a re-install of an existing VPN updates that entry without moving the pointer.
- tlb_enable = 1 with no mapping → tlb_hit = 0, cache_hit = 0, mem_req stays 0.
- Byte store 0xA5 to cached address 0x41 → mem_be = 4'b0010, mem_wdata = 0xA5A5A5A5. A later word load of 0x40 hits with data 0x0000A511. A byte load of 0x41 returns 0x000000A5.
- Store miss to 0x80 → memory write issued, no allocate. A subsequent load of 0x80 misses and refills.
- Assert rst_n low while in REFILL, then ack arrives → mem_req = 0, no line written, FSM in IDLE, all lookups miss.

Source files
------------

// File: rtl/cpu_dmem_responder.sv
// cpu_dmem_responder: responder end of the commit-stage memory interface.
// Holds a fully associative data TLB and a direct-mapped, write-through,
// read-allocate data cache. Load misses refill a whole line and every store
// is written through, both over a single-outstanding req/ack memory port.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   tlb_enable/write/addr/data  translation control, lookup and install
//   tlb_hit                     translation valid (combinational)
//   cache_read/write/mode/addr  access request, held by the requester
//   cache_data_in               store data
//   cache_hit, cache_data_out   access complete / load data
//   mem_req/we/addr/wdata/be    memory request (registered)
//   mem_ack, mem_rdata          memory completion and refill line

package cpu_dmem_responder_pkg;

  typedef enum logic [0:0] {
    CACHE_MODE_WORD = 1'b0,
    CACHE_MODE_BYTE = 1'b1
  } cache_mode_e;

endpackage

module cpu_dmem_responder
  import cpu_dmem_responder_pkg::*;
#(
  parameter int unsigned VADDR_W     = 32,
  parameter int unsigned PADDR_W     = 20,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned PAGE_BITS   = 12,
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned CACHE_LINES = 4,
  parameter int unsigned LINE_WORDS  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tlb_enable,
  input  logic                         tlb_write,
  input  logic [VADDR_W-1:0]           tlb_addr,
  input  logic [PADDR_W-1:0]           tlb_data,
  output logic                         tlb_hit,
  input  logic                         cache_read,
  input  logic                         cache_write,
  input  cache_mode_e                  cache_mode,
  input  logic [VADDR_W-1:0]           cache_addr,
  input  logic [WORD_W-1:0]            cache_data_in,
  output logic                         cache_hit,
  output logic [WORD_W-1:0]            cache_data_out,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [PADDR_W-1:0]           mem_addr,
  output logic [WORD_W-1:0]            mem_wdata,
  output logic [3:0]                   mem_be,
  input  logic                         mem_ack,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_rdata
);

  localparam int unsigned VPN_W      = VADDR_W - PAGE_BITS;
  localparam int unsigned PPN_W      = PADDR_W - PAGE_BITS;
  localparam int unsigned TLB_IDX_W  = $clog2(TLB_ENTRIES);
  localparam int unsigned WORD_OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W      = $clog2(CACHE_LINES);
  localparam int unsigned TAG_W      = PADDR_W - OFF_W - IDX_W;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_STORE,
    ST_RESP
  } state_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [TLB_ENTRIES-1:0] tlb_valid_q, tlb_valid_d;
  logic [VPN_W-1:0]       tlb_vpn_q [TLB_ENTRIES];
  logic [VPN_W-1:0]       tlb_vpn_d [TLB_ENTRIES];
  logic [PPN_W-1:0]       tlb_ppn_q [TLB_ENTRIES];
  logic [PPN_W-1:0]       tlb_ppn_d [TLB_ENTRIES];
  logic [TLB_IDX_W-1:0]   tlb_ptr_q, tlb_ptr_d;

  logic [CACHE_LINES-1:0] cache_valid_q, cache_valid_d;
  logic [TAG_W-1:0]       cache_tag_q [CACHE_LINES];
  logic [TAG_W-1:0]       cache_tag_d [CACHE_LINES];
  line_t                  cache_data_q [CACHE_LINES];
  line_t                  cache_data_d [CACHE_LINES];

  state_e                 state_q, state_d;
  logic [PADDR_W-1:0]     lat_paddr_q, lat_paddr_d;
  cache_mode_e            lat_mode_q, lat_mode_d;
  logic                   resp_q, resp_d;
  logic [WORD_W-1:0]      resp_data_q, resp_data_d;

  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [PADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]             mem_be_q, mem_be_d;

  // ---------------------------------------------------------------------
  // Byte loads are zero-extended; word loads ignore the byte offset.
  // ---------------------------------------------------------------------
  function automatic logic [WORD_W-1:0] load_format(input logic [WORD_W-1:0] word,
                                                    input cache_mode_e      mode,
                                                    input logic [1:0]       bsel);
    logic [7:0] sel_byte;
    sel_byte = 8'(word >> {bsel, 3'b000});
    return (mode == CACHE_MODE_BYTE) ? WORD_W'(sel_byte) : word;
  endfunction

  // ---------------------------------------------------------------------
  // TLB lookup and address translation
  // ---------------------------------------------------------------------
  logic [VPN_W-1:0]     lookup_vpn;
  logic                 tlb_match;
  logic [TLB_IDX_W-1:0] tlb_match_idx;
  logic [PPN_W-1:0]     tlb_match_ppn;
  logic [PADDR_W-1:0]   paddr;

  assign lookup_vpn = tlb_addr[VADDR_W-1:PAGE_BITS];

  always_comb begin
    tlb_match     = 1'b0;
    tlb_match_idx = '0;
    tlb_match_ppn = '0;
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      if (tlb_valid_q[i] && (tlb_vpn_q[i] == lookup_vpn)) begin
        tlb_match     = 1'b1;
        tlb_match_idx = TLB_IDX_W'(i);
        tlb_match_ppn = tlb_ppn_q[i];
      end
    end
  end

  assign tlb_hit = !tlb_enable || tlb_match;
  assign paddr   = tlb_enable ? {tlb_match_ppn, cache_addr[PAGE_BITS-1:0]}
                              : cache_addr[PADDR_W-1:0];

  // ---------------------------------------------------------------------
  // Cache lookup for the incoming request and for the latched one
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]      acc_idx, lat_idx;
  logic [TAG_W-1:0]      acc_tag, lat_tag;
  logic [WORD_OFF_W-1:0] acc_woff, lat_woff;
  logic                  line_hit;
  logic                  access_valid;
  logic                  load_hit;
  logic [WORD_W-1:0]     hit_word;
  line_t                 refill_line;

  assign acc_idx  = paddr[OFF_W +: IDX_W];
  assign acc_tag  = paddr[PADDR_W-1 -: TAG_W];
  assign acc_woff = paddr[2 +: WORD_OFF_W];
  assign lat_idx  = lat_paddr_q[OFF_W +: IDX_W];
  assign lat_tag  = lat_paddr_q[PADDR_W-1 -: TAG_W];
  assign lat_woff = lat_paddr_q[2 +: WORD_OFF_W];

  assign line_hit    = cache_valid_q[acc_idx] && (cache_tag_q[acc_idx] == acc_tag);
  assign hit_word    = cache_data_q[acc_idx][acc_woff];
  assign refill_line = mem_rdata;

  // An install cycle and a TLB miss both suppress the cache access.
  assign access_valid = (state_q == ST_IDLE) && !tlb_write && tlb_hit &&
                        (cache_read || cache_write);
  assign load_hit     = access_valid && !cache_write && line_hit;

  // Load hits answer in the same cycle; misses and stores answer from RESP.
  assign cache_hit      = load_hit || resp_q;
  assign cache_data_out = load_hit ? load_format(hit_word, cache_mode, paddr[1:0])
                                   : resp_data_q;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  // ---------------------------------------------------------------------
  // Next-state logic: TLB install, FSM, cache update, memory request
  // ---------------------------------------------------------------------
  always_comb begin
    logic [TLB_IDX_W-1:0] wr_idx;

    tlb_valid_d   = tlb_valid_q;
    tlb_vpn_d     = tlb_vpn_q;
    tlb_ppn_d     = tlb_ppn_q;
    tlb_ptr_d     = tlb_ptr_q;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    state_d       = state_q;
    lat_paddr_d   = lat_paddr_q;
    lat_mode_d    = lat_mode_q;
    resp_d        = 1'b0;
    resp_data_d   = '0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    wr_idx        = tlb_ptr_q;

    // Re-installing a known VPN updates in place and leaves the pointer alone.
    if (tlb_write) begin
      if (tlb_match) begin
        wr_idx = tlb_match_idx;
      end else begin
        tlb_ptr_d = tlb_ptr_q + TLB_IDX_W'(1);
      end
      tlb_valid_d[wr_idx] = 1'b1;
      tlb_vpn_d[wr_idx]   = lookup_vpn;
      tlb_ppn_d[wr_idx]   = tlb_data[PADDR_W-1:PAGE_BITS];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (access_valid) begin
          lat_paddr_d = paddr;
          lat_mode_d  = cache_mode;
          if (cache_write) begin
            state_d    = ST_STORE;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = {paddr[PADDR_W-1:2], 2'b00};
            if (cache_mode == CACHE_MODE_BYTE) begin
              mem_be_d    = 4'(4'b0001 << paddr[1:0]);
              mem_wdata_d = {4{cache_data_in[7:0]}};
            end else begin
              mem_be_d    = 4'b1111;
              mem_wdata_d = cache_data_in;
            end
          end else if (!line_hit) begin
            state_d    = ST_REFILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_be_d   = 4'b0000;
            mem_addr_d = {paddr[PADDR_W-1:OFF_W], OFF_W'(0)};
          end
        end
      end

      ST_REFILL: begin
        if (mem_ack) begin
          cache_valid_d[lat_idx] = 1'b1;
          cache_tag_d[lat_idx]   = lat_tag;
          cache_data_d[lat_idx]  = refill_line;
          resp_d      = 1'b1;
          resp_data_d = load_format(refill_line[lat_woff], lat_mode_q, lat_paddr_q[1:0]);
          mem_req_d   = 1'b0;
          state_d     = ST_RESP;
        end
      end

      ST_STORE: begin
        if (mem_ack) begin
          // Write-through without allocate: only a resident line is updated.
          if (cache_valid_q[lat_idx] && (cache_tag_q[lat_idx] == lat_tag)) begin
            for (int b = 0; b < 4; b++) begin
              if (mem_be_q[b]) begin
                cache_data_d[lat_idx][lat_woff][b*8 +: 8] = mem_wdata_q[b*8 +: 8];
              end
            end
          end
          resp_d    = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlb_valid_q   <= '0;
      tlb_ptr_q     <= '0;
      cache_valid_q <= '0;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
        tlb_vpn_q[i] <= '0;
        tlb_ppn_q[i] <= '0;
      end
      for (int i = 0; i < int'(CACHE_LINES); i++) begin
        cache_tag_q[i]  <= '0;
        cache_data_q[i] <= '0;
      end
      state_q     <= ST_IDLE;
      lat_paddr_q <= '0;
      lat_mode_q  <= CACHE_MODE_WORD;
      resp_q      <= 1'b0;
      resp_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      tlb_valid_q   <= tlb_valid_d;
      tlb_vpn_q     <= tlb_vpn_d;
      tlb_ppn_q     <= tlb_ppn_d;
      tlb_ptr_q     <= tlb_ptr_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
      state_q       <= state_d;
      lat_paddr_q   <= lat_paddr_d;
      lat_mode_q    <= lat_mode_d;
      resp_q        <= resp_d;
      resp_data_q   <= resp_data_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
    end
  end

  // Address bits that carry no information for this configuration.
  logic unused_bits;
  assign unused_bits = ^{tlb_addr[PAGE_BITS-1:0], tlb_data[PAGE_BITS-1:0],
                         cache_addr[VADDR_W-1:PADDR_W]};

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Self-checking bench for cpu_dmem_responder: directed scenarios followed by
// randomized traffic, compared against a page-table / line-presence model
// with a word-addressed backing memory that also answers the memory port.

module tb_cpu_dmem_responder;
  import cpu_dmem_responder_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         tlb_enable;
  logic         tlb_write;
  logic [31:0]  tlb_addr;
  logic [19:0]  tlb_data;
  logic         tlb_hit;
  logic         cache_read;
  logic         cache_write;
  cache_mode_e  cache_mode;
  logic [31:0]  cache_addr;
  logic [31:0]  cache_data_in;
  logic         cache_hit;
  logic [31:0]  cache_data_out;
  logic         mem_req;
  logic         mem_we;
  logic [19:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_ack;
  logic [127:0] mem_rdata;

  cpu_dmem_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tlb_enable     (tlb_enable),
    .tlb_write      (tlb_write),
    .tlb_addr       (tlb_addr),
    .tlb_data       (tlb_data),
    .tlb_hit        (tlb_hit),
    .cache_read     (cache_read),
    .cache_write    (cache_write),
    .cache_mode     (cache_mode),
    .cache_addr     (cache_addr),
    .cache_data_in  (cache_data_in),
    .cache_hit      (cache_hit),
    .cache_data_out (cache_data_out),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: page table, line presence, backing memory.
  bit         m_tv   [4];
  bit [19:0]  m_tvpn [4];
  bit [7:0]   m_tppn [4];
  int         m_tptr;
  bit         m_cv   [4];
  bit [13:0]  m_ctag [4];
  bit [31:0]  mem    [int unsigned];

  function automatic bit [31:0] mem_rd(input int unsigned wa);
    if (mem.exists(wa)) return mem[wa];
    return 32'h5EED_0000 ^ wa;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_tv[i] = 1'b0;
      m_cv[i] = 1'b0;
    end
    m_tptr = 0;
  endtask

  task automatic translate(input bit en, input logic [31:0] va, output bit hit, output logic [19:0] pa);
    hit = !en;
    pa  = va[19:0];
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (m_tv[i] && m_tvpn[i] == va[31:12]) begin
          hit = 1'b1;
          pa  = {m_tppn[i], va[11:0]};
        end
      end
    end
  endtask

  task automatic model_install(input logic [31:0] va, input logic [19:0] pa);
    int slot;
    slot = -1;
    for (int i = 0; i < 4; i++) if (m_tv[i] && m_tvpn[i] == va[31:12]) slot = i;
    if (slot < 0) begin
      slot   = m_tptr;
      m_tptr = (m_tptr + 1) % 4;
    end
    m_tv[slot]   = 1'b1;
    m_tvpn[slot] = va[31:12];
    m_tppn[slot] = pa[19:12];
  endtask

  // Memory responder: random wait, logs each request, applies writes.
  bit          auto_ack = 1'b1;
  int          man_req_cnt = 0;
  int          man_done = 0;
  int          req_cnt = 0;
  int          last_wait = 0;
  bit          last_we;
  logic [19:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;

  initial begin
    bit          in_txn;
    int          wcnt;
    int unsigned wa;
    logic [31:0] w;
    in_txn    = 1'b0;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (man_done != man_req_cnt) begin
        man_done++;
        mem_ack   = 1'b1;
        mem_rdata = {4{32'hBAD0_BAD0}};
      end else if (auto_ack && mem_req) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          wcnt      = $urandom_range(0, 3);
          last_wait = wcnt;
        end
        if (wcnt == 0) begin
          in_txn     = 1'b0;
          req_cnt++;
          last_we    = mem_we;
          last_addr  = mem_addr;
          last_wdata = mem_wdata;
          last_be    = mem_be;
          wa = 32'(mem_addr >> 2);
          if (mem_we) begin
            w = mem_rd(wa);
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
            mem[wa] = w;
          end else begin
            for (int k = 0; k < 4; k++) mem_rdata[k*32 +: 32] = mem_rd(wa + 32'(k));
          end
          mem_ack = 1'b1;
        end else begin
          wcnt--;
        end
      end
    end
  end

  task automatic drop_req();
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  // One complete load or store, checked end to end.
  task automatic access(input bit st, input bit bm, input bit en, input logic [31:0] va,
                        input logic [31:0] wd);
    bit          th, exp_hit, got;
    logic [19:0] pa;
    logic [1:0]  idx;
    logic [13:0] tag;
    logic [31:0] w, exp_data;
    int          prev, cyc;
    translate(en, va, th, pa);
    idx      = pa[5:4];
    tag      = pa[19:6];
    w        = mem_rd(32'(pa >> 2));
    exp_data = bm ? {24'h0, 8'(w >> {pa[1:0], 3'b000})} : w;
    exp_hit  = !st && m_cv[idx] && (m_ctag[idx] == tag);

    @(negedge clk);
    tlb_enable    = en;
    tlb_addr      = va;
    cache_addr    = va;
    cache_mode    = bm ? CACHE_MODE_BYTE : CACHE_MODE_WORD;
    cache_data_in = wd;
    cache_write   = st;
    cache_read    = st ? 1'($urandom_range(0, 1)) : 1'b1;
    prev          = req_cnt;
    #1;
    check_eq("tlb_hit", 32'(tlb_hit), 32'(th));
    if (!th) begin
      check_eq("tlb_miss_no_hit", 32'(cache_hit), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("tlb_miss_no_mem", 32'(req_cnt - prev) + 32'(mem_req), 32'd0);
      drop_req();
      return;
    end
    if (exp_hit) begin
      check_eq("ld_hit", 32'(cache_hit), 32'd1);
      check_eq("ld_hit_data", cache_data_out, exp_data);
      @(negedge clk);
      check_eq("ld_hit_no_mem", 32'(mem_req), 32'd0);
      drop_req();
      return;
    end
    check_eq("miss_no_early_hit", 32'(cache_hit), 32'd0);
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (cache_hit) begin
        got = 1'b1;
        cyc = c;
        break;
      end
    end
    check_eq("resp_seen", 32'(got), 32'd1);
    if (!got) begin
      drop_req();
      return;
    end
    if (!st) check_eq("refill_data", cache_data_out, exp_data);
    drop_req();
    check_eq("req_count", 32'(req_cnt - prev), 32'd1);
    check_eq("mem_we", 32'(last_we), 32'(st));
    check_eq("mem_addr", 32'(last_addr), st ? 32'({pa[19:2], 2'b00}) : 32'({pa[19:4], 4'h0}));
    if (st) begin
      check_eq("mem_be", 32'(last_be), bm ? 32'(4'(4'b0001 << pa[1:0])) : 32'hF);
      check_eq("mem_wdata", last_wdata, bm ? {4{wd[7:0]}} : wd);
    end
    check_eq("resp_cycles", 32'(cyc), 32'(2 + last_wait));
    @(negedge clk);
    check_eq("hit_one_cycle", 32'(cache_hit), 32'd0);
    check_eq("req_dropped", 32'(mem_req), 32'd0);
    if (!st) begin
      m_cv[idx]   = 1'b1;
      m_ctag[idx] = tag;
    end
  endtask

  task automatic tlb_install(input logic [31:0] va, input logic [19:0] pa);
    @(negedge clk);
    drop_req();
    tlb_write = 1'b1;
    tlb_addr  = va;
    tlb_data  = pa;
    model_install(va, pa);
    @(negedge clk);
    tlb_write  = 1'b0;
    tlb_enable = 1'b1;
    #1;
    check_eq("tlb_visible", 32'(tlb_hit), 32'd1);
  endtask

  task automatic tlb_probe(input string tag, input logic [31:0] va, input bit exp);
    @(negedge clk);
    drop_req();
    tlb_enable = 1'b1;
    tlb_addr   = va;
    cache_addr = va;
    #1;
    check_eq(tag, 32'(tlb_hit), 32'(exp));
  endtask

  logic [19:0] vpn_pool [6] = '{20'h12345, 20'h00001, 20'h00002, 20'h7FFFF, 20'h00ABC, 20'h00003};
  logic [7:0]  ppn_pool [4] = '{8'h00, 8'h01, 8'hAB, 8'h40};

  initial begin
    int prev;
    bit seen;
    rst_n         = 1'b1;
    tlb_enable    = 1'b1;
    tlb_write     = 1'b0;
    tlb_addr      = '0;
    tlb_data      = '0;
    cache_read    = 1'b0;
    cache_write   = 1'b0;
    cache_mode    = CACHE_MODE_WORD;
    cache_addr    = '0;
    cache_data_in = '0;
    model_clear();
    mem[32'h10] = 32'h11;
    mem[32'h11] = 32'h22;
    mem[32'h12] = 32'h33;
    mem[32'h13] = 32'h44;
    #3 rst_n = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_tlb_hit", 32'(tlb_hit), 32'd0);
    check_eq("rst_cache_hit", 32'(cache_hit), 32'd0);
    check_eq("rst_data_out", cache_data_out, 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity-mapped refill, hit, byte store merge, store miss.
    access(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    access(1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
    access(1'b1, 1'b1, 1'b0, 32'h0000_0041, 32'h0000_00A5);
    access(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0041, 32'h0);
    access(1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'hCAFE_F00D);
    access(1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0083, 32'h0);

    // Translation, replacement pointer, in-place re-install.
    access(1'b0, 1'b0, 1'b1, 32'h1234_5008, 32'h0);
    tlb_install(32'h1234_5000, 20'hAB000);
    access(1'b0, 1'b0, 1'b1, 32'h1234_5008, 32'h0);
    tlb_install(32'h0000_1000, 20'h01000);
    tlb_install(32'h0000_2000, 20'h02000);
    tlb_install(32'h0000_3000, 20'h03000);
    tlb_install(32'h0000_2000, 20'h40000);
    tlb_install(32'h00AB_C000, 20'h05000);
    tlb_probe("tlb_evicted_e0", 32'h1234_5000, 1'b0);
    tlb_probe("tlb_kept_e1", 32'h0000_1000, 1'b1);
    tlb_probe("tlb_kept_e3", 32'h0000_3000, 1'b1);
    access(1'b0, 1'b0, 1'b1, 32'h0000_2010, 32'h0);

    // An install cycle swallows a simultaneous cache request.
    @(negedge clk);
    prev        = req_cnt;
    tlb_enable  = 1'b0;
    tlb_write   = 1'b1;
    tlb_addr    = 32'h0000_0300;
    tlb_data    = 20'h01000;
    cache_addr  = 32'h0000_0300;
    cache_mode  = CACHE_MODE_WORD;
    cache_read  = 1'b1;
    model_install(32'h0000_0300, 20'h01000);
    #1;
    check_eq("install_no_hit", 32'(cache_hit), 32'd0);
    @(negedge clk);
    tlb_write = 1'b0;
    drop_req();
    repeat (2) @(negedge clk);
    check_eq("install_no_mem", 32'(req_cnt - prev) + 32'(mem_req), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 160; n++) begin
      bit          en;
      logic [31:0] va;
      if ($urandom_range(0, 9) < 2) begin
        tlb_install({vpn_pool[$urandom_range(0, 5)], 12'h000},
                    {ppn_pool[$urandom_range(0, 3)], 12'h000});
      end else begin
        en = ($urandom_range(0, 3) != 0);
        if (en) va = {vpn_pool[$urandom_range(0, 5)], 4'h0, 8'($urandom_range(0, 255))};
        else    va = {12'($urandom), ppn_pool[$urandom_range(0, 3)], 4'h0, 8'($urandom_range(0, 255))};
        access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), en, va, $urandom);
      end
    end

    // Reset in the middle of a refill; a late ack must be ignored.
    auto_ack = 1'b0;
    @(negedge clk);
    tlb_enable = 1'b0;
    tlb_addr   = 32'h0000_0F00;
    cache_addr = 32'h0000_0F00;
    cache_mode = CACHE_MODE_WORD;
    cache_read = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("rst_refill_req", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req", 32'(mem_req), 32'd0);
    check_eq("rst_mid_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mid_hit", 32'(cache_hit), 32'd0);
    drop_req();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    prev  = req_cnt;
    man_req_cnt++;
    repeat (3) @(negedge clk);
    check_eq("late_ack_no_req", 32'(mem_req), 32'd0);
    check_eq("late_ack_no_hit", 32'(cache_hit), 32'd0);
    auto_ack = 1'b1;
    access(1'b0, 1'b0, 1'b0, 32'h0000_0F00, 32'h0);
    access(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    tlb_probe("rst_tlb_cleared", 32'h0000_1000, 1'b0);
    access(1'b0, 1'b0, 1'b1, 32'h0000_1008, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
